img2col_map_ctrl_p: RTL and testbench



---
 rtl/img2col_pkg.sv | 26 ++
 rtl/img2col_addr_cnt.sv | 71 +++++++
 rtl/img2col_map_ctrl_p.sv | 208 ++++++++++++++++++++
 tb/tb_img2col_map_ctrl_p.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// img2col_pkg: shared types and constants for the img2col mapping controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   ST_IDLE/ST_BUFFER/ST_WORK : raw 2-bit state encodings
//   map_state_e               : controller state enum built on those encodings
//   STALL_CNT_W               : width of the optional stall counter
//                               (present only with IMG2COL_MAP_STALL_CNT_EN)
package img2col_pkg;

    // The encodings are fixed constants so that older code comparing
    // against raw state values keeps working.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUFFER = 2'd1;
    localparam logic [1:0] ST_WORK   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        BUFFER = ST_BUFFER,
        WORK   = ST_WORK
    } map_state_e;

    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/img2col_addr_cnt.sv
// img2col_addr_cnt: nested sub-address / PU-index wrap counter.
// Latency: counts are registered; the last_addr_o/wrap_o flags are combinational from them.
// Backpressure: adv_i low holds both counts; clr_i forces both to zero.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : synchronous clear of both counts (wins over adv_i)
//   adv_i         : advance the sub-address by one this cycle
//   addr_o        : sub-address within the current PU, 0..KSIZE-1
//   pu_o          : PU index, 0..NUM_PU-1
//   last_addr_o   : addr_o is at KSIZE-1
//   wrap_o        : this advance leaves the last address of the last PU
module img2col_addr_cnt #(
    parameter  int NUM_PU = 28,
    parameter  int KSIZE  = 5,
    localparam int PU_W   = $clog2(NUM_PU),
    localparam int K_W    = $clog2(KSIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            adv_i,
    output logic [K_W-1:0]  addr_o,
    output logic [PU_W-1:0] pu_o,
    output logic            last_addr_o,
    output logic            wrap_o
);

    localparam logic [K_W-1:0]  ADDR_LAST = K_W'(KSIZE - 1);
    localparam logic [PU_W-1:0] PU_LAST   = PU_W'(NUM_PU - 1);

    logic [K_W-1:0]  addr_q, addr_d;
    logic [PU_W-1:0] pu_q,   pu_d;
    logic            pu_last;

    assign pu_last     = (pu_q == PU_LAST);
    assign last_addr_o = (addr_q == ADDR_LAST);
    assign wrap_o      = adv_i && last_addr_o && pu_last;

    always_comb begin
        addr_d = addr_q;
        pu_d   = pu_q;
        if (clr_i) begin
            addr_d = '0;
            pu_d   = '0;
        end else if (adv_i) begin
            if (last_addr_o) begin
                // Leaving the last sub-address moves on to the next PU,
                // and the last PU rolls back to PU 0.
                addr_d = '0;
                pu_d   = pu_last ? '0 : pu_q + PU_W'(1);
            end else begin
                addr_d = addr_q + K_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            pu_q   <= '0;
        end else begin
            addr_q <= addr_d;
            pu_q   <= pu_d;
        end
    end

    assign addr_o = addr_q;
    assign pu_o   = pu_q;

endmodule

// File: rtl/img2col_map_ctrl_p.sv
// img2col_map_ctrl_p: parametrised img2col mapping controller (row buffering preload, then per-round PU sweeps).
// Latency: every output is registered, so an input is reflected on the outputs one cycle later.
// Backpressure: a low pu_done_i[pu_no] at the last sub-address stalls the sweep; start_i is ignored while busy.
//
// Optional feature macro: IMG2COL_MAP_STALL_CNT_EN adds stall_cnt_o. Without it
// that port and its counter are absent and everything else is unchanged.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (overrides all inputs)
//   start_i       : one-cycle job request, sampled only in IDLE
//   cfg_rounds_i  : working rounds for the job, latched on an accepted start (0 runs as 1)
//   stop_i        : level; ends the job at the next round boundary
//   pu_done_i     : per-PU flag saying the PU can take its next row
//   pu1_addr_o    : sub-address within the current PU
//   pu_no_o       : current PU index
//   row_no_o      : buffering row index (preload phase only)
//   round_o       : current working round
//   act_o         : one-cycle pulse when a new round starts
//   map_finish_o  : one-cycle pulse when the job completes
//   busy_o        : high while buffering or working
//   stall_cnt_o   : (macro only) saturating count of stalled WORK cycles
module img2col_map_ctrl_p
    import img2col_pkg::*;
#(
    parameter  int NUM_PU = 28,
    parameter  int KSIZE  = 5,
    parameter  int RND_W  = 6,
    localparam int PU_W   = $clog2(NUM_PU),
    localparam int K_W    = $clog2(KSIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [RND_W-1:0]       cfg_rounds_i,
    input  logic                   stop_i,
    input  logic [NUM_PU-1:0]      pu_done_i,
    output logic [K_W-1:0]         pu1_addr_o,
    output logic [PU_W-1:0]        pu_no_o,
    output logic [K_W-1:0]         row_no_o,
    output logic [RND_W-1:0]       round_o,
    output logic                   act_o,
    output logic                   map_finish_o,
    output logic                   busy_o
`ifdef IMG2COL_MAP_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    // The preload fills KSIZE-1 rows, so the last buffering row is KSIZE-2.
    localparam logic [K_W-1:0]   ROW_LAST = K_W'(KSIZE - 2);
    localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);

    map_state_e       state_q,  state_d;
    logic [RND_W-1:0] rounds_q, rounds_d;   // latched job length, never 0 while busy
    logic [K_W-1:0]   row_q,    row_d;
    logic [RND_W-1:0] round_q,  round_d;
    logic             act_q,    act_d;
    logic             fin_q,    fin_d;
    logic             busy_q,   busy_d;

    logic [K_W-1:0]   cnt_addr;
    logic [PU_W-1:0]  cnt_pu;
    logic             cnt_clr;
    logic             cnt_adv;
    logic             cnt_last_addr;
    logic             cnt_wrap;
    logic             cur_pu_done;
    logic             last_round;

    assign cur_pu_done = pu_done_i[cnt_pu];
    assign last_round  = (round_q == (rounds_q - RND_ONE));

    // IDLE keeps the counters parked at zero. BUFFER advances every cycle.
    // WORK moves freely below the last sub-address and only leaves the last
    // sub-address once the current PU reports done.
    assign cnt_clr = (state_q == IDLE);
    assign cnt_adv = (state_q == BUFFER) ||
                     ((state_q == WORK) && (!cnt_last_addr || cur_pu_done));

    img2col_addr_cnt #(
        .NUM_PU (NUM_PU),
        .KSIZE  (KSIZE)
    ) u_addr_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr),
        .adv_i       (cnt_adv),
        .addr_o      (cnt_addr),
        .pu_o        (cnt_pu),
        .last_addr_o (cnt_last_addr),
        .wrap_o      (cnt_wrap)
    );

`ifdef IMG2COL_MAP_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   stall_w;

    assign stall_w = (state_q == WORK) && cnt_last_addr && !cur_pu_done;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start_i) begin
            stall_cnt_d = '0;
        end else if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        row_d    = row_q;
        round_d  = round_q;
        act_d    = 1'b0;
        fin_d    = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                // Clearing here (rather than at the finishing edge) lets the
                // final round number stay visible during the map_finish cycle.
                row_d   = '0;
                round_d = '0;
                busy_d  = 1'b0;
                if (start_i) begin
                    state_d  = BUFFER;
                    busy_d   = 1'b1;
                    rounds_d = (cfg_rounds_i == '0) ? RND_ONE : cfg_rounds_i;
                end
            end

            BUFFER: begin
                // One buffering row is a full sweep over all PUs. pu_done_i
                // and stop_i have no effect during the preload.
                if (cnt_wrap) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        round_d = '0;
                        state_d = WORK;
                    end else begin
                        row_d = row_q + K_W'(1);
                    end
                end
            end

            WORK: begin
                // stop_i only counts at a round boundary. The counter wraps
                // back to PU 0 / address 0 by itself on the same edge.
                if (cnt_wrap) begin
                    if (last_round || stop_i) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        round_d = round_q + RND_ONE;
                        act_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rounds_q <= '0;
            row_q    <= '0;
            round_q  <= '0;
            act_q    <= 1'b0;
            fin_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
            row_q    <= row_d;
            round_q  <= round_d;
            act_q    <= act_d;
            fin_q    <= fin_d;
            busy_q   <= busy_d;
        end
    end

    assign pu1_addr_o   = cnt_addr;
    assign pu_no_o      = cnt_pu;
    assign row_no_o     = row_q;
    assign round_o      = round_q;
    assign act_o        = act_q;
    assign map_finish_o = fin_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_img2col_map_ctrl_p.sv
// tb_img2col_map_ctrl_p: directed, table-driven bench for img2col_map_ctrl_p (NUM_PU=4, KSIZE=3, RND_W=6).
// Latency: n/a (testbench).
// Backpressure: drives pu_done_i low on one PU to create stalls.
//
// With NUM_PU=4 and KSIZE=3 the preload is 2*4*3 = 24 cycles and one round
// is 4*3 = 12 cycles. Inputs change on the falling edge and outputs are read
// there too. Cycle 0 is the first falling edge after the start is accepted.
// stall_cnt_o is connected and checked only with IMG2COL_MAP_STALL_CNT_EN.
module tb_img2col_map_ctrl_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [5:0] cfg_rounds_i;
    logic       stop_i;
    logic [3:0] pu_done_i;
    logic [1:0] pu1_addr_o;
    logic [1:0] pu_no_o;
    logic [1:0] row_no_o;
    logic [5:0] round_o;
    logic       act_o;
    logic       map_finish_o;
    logic       busy_o;
`ifdef IMG2COL_MAP_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    img2col_map_ctrl_p #(
        .NUM_PU (4),
        .KSIZE  (3),
        .RND_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .cfg_rounds_i (cfg_rounds_i),
        .stop_i       (stop_i),
        .pu_done_i    (pu_done_i),
        .pu1_addr_o   (pu1_addr_o),
        .pu_no_o      (pu_no_o),
        .row_no_o     (row_no_o),
        .round_o      (round_o),
        .act_o        (act_o),
        .map_finish_o (map_finish_o),
        .busy_o       (busy_o)
`ifdef IMG2COL_MAP_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    // One job per record: the stimulus, then the hand-computed outcome.
    typedef struct {
        logic [5:0] cfg;        // cfg_rounds_i at start
        int         stop_rnd;   // raise stop_i inside this round (-1: never)
        int         stall_pu;   // PU whose pu_done is pulled low
        int         stall_len;  // stall length in cycles (0: none)
        bit         glitch;     // extra starts while busy, cfg changed while busy
        int         exp_fin;    // cycle index at which map_finish_o is seen
        int         exp_act;    // number of act_o pulses
        int         exp_round;  // round_o during the map_finish_o cycle
        int         exp_hold;   // cycles the stalled position stays put
        int         exp_stall;  // stall_cnt_o after the job
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic b, input logic a, input logic [5:0] r,
                                         input logic [1:0] row, input logic [1:0] pu,
                                         input logic [1:0] ad);
        return {18'd0, b, a, r, row, pu, ad};
    endfunction

    function automatic logic [31:0] obs();
        return pack(busy_o, act_o, round_o, row_no_o, pu_no_o, pu1_addr_o);
    endfunction

    // Run one job from IDLE, checking the buffering and (stall-free) working
    // sequence every cycle against closed-form positions.
    task automatic run_job(input vec_t v, output int fin_cyc, output int act_cnt,
                           output int fin_round, output int hold_cnt);
        int  stall_rem;
        bit  stall_done;
        int  j;
        fin_cyc    = -1;
        act_cnt    = 0;
        fin_round  = -1;
        hold_cnt   = 0;
        stall_rem  = 0;
        stall_done = 1'b0;
        @(negedge clk);
        start_i      = 1'b1;
        cfg_rounds_i = v.cfg;
        pu_done_i    = 4'hf;
        stop_i       = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start_i = 1'b0;
            if (v.glitch && (cyc == 5 || cyc == 30)) start_i = 1'b1;
            if (v.glitch && cyc == 1) cfg_rounds_i = 6'd9;
            if (act_o) act_cnt++;
            if (map_finish_o) begin
                fin_cyc   = cyc;
                fin_round = int'(round_o);
                check("finish_cycle_state", pack(busy_o, act_o, 6'd0, row_no_o, pu_no_o, pu1_addr_o), 32'd0);
                break;
            end
            if (cyc < 24) begin
                check($sformatf("buffer_seq_c%0d", cyc), obs(),
                      pack(1'b1, 1'b0, 6'd0, 2'(cyc / 12), 2'((cyc / 3) % 4), 2'(cyc % 3)));
            end else if (v.stall_len == 0) begin
                j = cyc - 24;
                check($sformatf("work_seq_j%0d", j), obs(),
                      pack(1'b1, (j > 0 && j % 12 == 0), 6'(j / 12), 2'd0, 2'((j / 3) % 4), 2'(j % 3)));
            end
            if (stall_rem > 0) begin
                if (pu_no_o == 2'(v.stall_pu) && pu1_addr_o == 2'd2) hold_cnt++;
                stall_rem--;
                if (stall_rem == 0) pu_done_i = 4'hf;
            end else if (!stall_done && v.stall_len > 0 && cyc >= 24 &&
                         pu_no_o == 2'(v.stall_pu) && pu1_addr_o == 2'd2) begin
                pu_done_i[v.stall_pu] = 1'b0;
                stall_rem  = v.stall_len;
                stall_done = 1'b1;
            end
            if (v.stop_rnd >= 0 && cyc >= 24 && round_o == 6'(v.stop_rnd) && pu_no_o == 2'd1)
                stop_i = 1'b1;
        end
        stop_i    = 1'b0;
        pu_done_i = 4'hf;
        start_i   = 1'b0;
        @(negedge clk);
        // Pulse is single-cycle, busy stays low, round cleared by IDLE.
        check("after_finish_clear", {24'd0, map_finish_o, busy_o, round_o}, 32'd0);
    endtask

    task automatic run_and_check(input int k);
        int fc, ac, fr, hc;
        run_job(tbl[k], fc, ac, fr, hc);
        check($sformatf("v%0d_finish_cycle", k), fc, tbl[k].exp_fin);
        check($sformatf("v%0d_act_count", k), ac, tbl[k].exp_act);
        check($sformatf("v%0d_final_round", k), fr, tbl[k].exp_round);
        check($sformatf("v%0d_stall_hold", k), hc, tbl[k].exp_hold);
`ifdef IMG2COL_MAP_STALL_CNT_EN
        check($sformatf("v%0d_stall_cnt", k), stall_cnt_o, tbl[k].exp_stall);
`endif
    endtask

    initial begin
        //            cfg    stop stpu slen gl  fin act rnd hold stall
        tbl[0] = '{6'd2,  -1,  0,   0,  0,  48,  1,  1,  0,   0};  // baseline 2 rounds
        tbl[1] = '{6'd2,  -1,  2,   5,  0,  53,  1,  1,  5,   5};  // PU2 stalls 5 cycles
        tbl[2] = '{6'd5,   1,  0,   0,  0,  48,  1,  1,  0,   0};  // stop inside round 1
        tbl[3] = '{6'd0,  -1,  0,   0,  0,  36,  0,  0,  0,   0};  // 0 runs as 1 round
        tbl[4] = '{6'd1,  -1,  0,   0,  0,  36,  0,  0,  0,   0};  // single round
        tbl[5] = '{6'd3,  -1,  0,   0,  0,  60,  2,  2,  0,   0};  // 3 rounds
        tbl[6] = '{6'd1,  -1,  0,   0,  1,  36,  0,  0,  0,   0};  // starts/cfg while busy

        rst          = 1'b1;
        start_i      = 1'b1;   // must be overridden by reset
        cfg_rounds_i = 6'd3;
        stop_i       = 1'b0;
        pu_done_i    = 4'hf;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {17'd0, map_finish_o, obs()}, 32'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {17'd0, map_finish_o, obs()}, 32'd0);

        for (int k = 0; k < 7; k++) run_and_check(k);

        // Reset in the middle of round 1 of a 3-round job.
        @(negedge clk);
        start_i      = 1'b1;
        cfg_rounds_i = 6'd3;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 100 && round_o != 6'd1; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        // Four cycles into round 1: PU 1, sub-address 1.
        check("pre_reset_position", {21'd0, busy_o, round_o, pu_no_o, pu1_addr_o}, 32'd1045);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_work", {17'd0, map_finish_o, obs()}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_after_reset", {17'd0, map_finish_o, obs()}, 32'd0);
        // A fresh start redoes the whole preload.
        run_and_check(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
